// File: rtl/led_chaser_pkg.sv
// Shared encodings for the mirrored LED chaser: pattern modes and the
// bounce direction flag.
package led_chaser_pkg;

  localparam logic [1:0] MODE_CONV   = 2'b00;
  localparam logic [1:0] MODE_DIV    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

endpackage

// File: rtl/led_mirror_chaser_tick_prescaler.sv
// Step-rate prescaler: one tick every Step_div+1 enabled cycles.
// Step_div is compared live against the running count, so lowering it
// below the count forces a tick on the next enabled cycle.
module tick_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             Clr,
  input  logic             En,
  input  logic [DIV_W-1:0] Step_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = En && (cnt >= Step_div);

  // Count enabled cycles, restart on tick or clear, hold while disabled.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (Clr) begin
      cnt <= '0;
    end else if (En) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_mirror_chaser.sv
// Mirrored N-LED chaser with converge, diverge, bounce and fill patterns.
// Bit i of the lower half is always mirrored onto bit N-1-i.
//
//   state          | meaning
//   k = H          | blank, LED all off; next tick loads k = 0
//   k = 0..H-1     | lit step index into the current pattern
//   dir = DIR_IN   | bounce walking toward the centre (k rising)
//   dir = DIR_OUT  | bounce walking back to the edges (k falling)
module led_mirror_chaser
  import led_chaser_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 24
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             Clr,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [DIV_W-1:0] Step_div,
  output logic [N-1:0]     LED,
  output logic             Step,
  output logic             Wrap
);

  localparam int H  = N / 2;
  localparam int KW = $clog2(H + 1);
  localparam logic [KW-1:0] K_BLANK = KW'(H);
  localparam logic [KW-1:0] K_LAST  = KW'(H - 1);
  localparam logic [KW-1:0] K_ONE   = KW'(1);

  logic          tick;
  logic [KW-1:0] k_q, k_nxt;
  logic          dir_q, dir_nxt;
  logic [1:0]    mode_q, mode_nxt;
  logic          wrap_nxt;
  logic [N-1:0]  led_nxt;
  logic          lit;

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .Clk      (Clk),
    .RST      (RST),
    .Clr      (Clr),
    .En       (En),
    .Step_div (Step_div),
    .tick     (tick)
  );

  // Next step index, direction and latched mode, applied on the next tick.
  always_comb begin
    k_nxt    = k_q;
    dir_nxt  = dir_q;
    mode_nxt = mode_q;
    wrap_nxt = 1'b0;
    if (Mode != mode_q) begin
      mode_nxt = Mode;
      k_nxt    = '0;
      dir_nxt  = DIR_IN;
    end else if (k_q == K_BLANK) begin
      k_nxt   = '0;
      dir_nxt = DIR_IN;
    end else if (mode_q != MODE_BOUNCE) begin
      if (k_q == K_LAST) begin
        k_nxt    = K_BLANK;
        wrap_nxt = 1'b1;
      end else begin
        k_nxt = k_q + 1'b1;
      end
    end else if (dir_q == DIR_IN) begin
      if (k_q == K_LAST) begin
        // Turning point at the centre; with H=2 this lands straight on 0.
        dir_nxt  = DIR_OUT;
        k_nxt    = k_q - 1'b1;
        wrap_nxt = (k_q == K_ONE);
      end else begin
        k_nxt = k_q + 1'b1;
      end
    end else begin
      if (k_q == '0) begin
        dir_nxt = DIR_IN;
        k_nxt   = k_q + 1'b1;
      end else begin
        k_nxt    = k_q - 1'b1;
        wrap_nxt = (k_q == K_ONE);
      end
    end
  end

  // Pattern decoder: lower-half bit pattern for (mode, k), mirrored upward.
  always_comb begin
    led_nxt = '0;
    lit     = 1'b0;
    if (k_nxt != K_BLANK) begin
      for (int i = 0; i < H; i++) begin
        case (mode_nxt)
          MODE_DIV:  lit = (i == H - 1 - int'(k_nxt));
          MODE_FILL: lit = (i <= int'(k_nxt));
          default:   lit = (i == int'(k_nxt));
        endcase
        led_nxt[i]         = lit;
        led_nxt[N - 1 - i] = lit;
      end
    end
  end

  // Sequencer state and registered outputs; Clr outranks a coincident tick.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      k_q    <= K_BLANK;
      dir_q  <= DIR_IN;
      mode_q <= MODE_CONV;
      LED    <= '0;
      Step   <= 1'b0;
      Wrap   <= 1'b0;
    end else if (Clr) begin
      k_q   <= K_BLANK;
      dir_q <= DIR_IN;
      LED   <= '0;
      Step  <= 1'b0;
      Wrap  <= 1'b0;
    end else if (tick) begin
      k_q    <= k_nxt;
      dir_q  <= dir_nxt;
      mode_q <= mode_nxt;
      LED    <= led_nxt;
      Step   <= 1'b1;
      Wrap   <= wrap_nxt;
    end else begin
      Step <= 1'b0;
      Wrap <= 1'b0;
    end
  end

endmodule
